// File: rtl/reg_file_sb.sv
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Integer register file (2R/1W, x0 hardwired zero) with a
//            per-register busy scoreboard for the ID-stage hazard unit.
//            Optional same-cycle write-through: define REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rd_addr1,
   input  logic [AW-1:0]   rd_addr2,
   output logic [XLEN-1:0] rd_data1,
   output logic [XLEN-1:0] rd_data2,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wd,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            busy1,
   output logic            busy2,
   output logic [AW:0]     pend_cnt
);

   logic [XLEN-1:0]  mem [0:NREGS-1];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             wr_en;

   assign wr_en = we && (waddr != '0);

   function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
      logic [AW:0] c;
      c = '0;
      for (int k = 0; k < NREGS; k++) begin
         c = c + {{AW{1'b0}}, v[k]};
      end
      return c;
   endfunction

   // Set has priority over clear: a same-edge issue names a newer producer.
   assign busy_nxt[0] = 1'b0;
   for (genvar i = 1; i < NREGS; i++) begin : g_busy
      assign busy_nxt[i] = (issue_valid && (issue_rd == AW'(i))) ||
                           (busy[i] && !(we && (waddr == AW'(i))));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NREGS; k++) begin
            mem[k] <= '0;
         end
      end else if (wr_en) begin
         mem[waddr] <= wd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         pend_cnt <= popcount(busy_nxt);
      end
   end

   always_comb begin
      rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
      rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];
      busy1    = busy[rd_addr1];
      busy2    = busy[rd_addr2];
`ifdef REGFILE_BYPASS_EN
      // Write-through: the landing write resolves the hazard unless a newer
      // producer for the same register issues in this very cycle.
      if (wr_en && (waddr == rd_addr1)) begin
         rd_data1 = wd;
         busy1    = issue_valid && (issue_rd == rd_addr1);
      end
      if (wr_en && (waddr == rd_addr2)) begin
         rd_data2 = wd;
         busy2    = issue_valid && (issue_rd == rd_addr2);
      end
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Directed self-checking bench for reg_file_sb (32x32 and 16x64).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 32 x 32 instance
   logic [4:0]  rd_addr1, rd_addr2, waddr, issue_rd;
   logic [31:0] rd_data1, rd_data2, wd;
   logic        we, issue_valid, busy1, busy2;
   logic [5:0]  pend_cnt;

   // 16 x 64 instance
   logic [3:0]  s_rd_addr1, s_rd_addr2, s_waddr, s_issue_rd;
   logic [63:0] s_rd_data1, s_rd_data2, s_wd;
   logic        s_we, s_issue_valid, s_busy1, s_busy2;
   logic [4:0]  s_pend_cnt;

   int n_cmp = 0;
   int n_err = 0;

   reg_file_sb dut (
      .clk(clk), .rst(rst),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .we(we), .waddr(waddr), .wd(wd),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
   );

   reg_file_sb #(.XLEN(64), .NREGS(16)) dut16 (
      .clk(clk), .rst(rst),
      .rd_addr1(s_rd_addr1), .rd_addr2(s_rd_addr2),
      .rd_data1(s_rd_data1), .rd_data2(s_rd_data2),
      .we(s_we), .waddr(s_waddr), .wd(s_wd),
      .issue_valid(s_issue_valid), .issue_rd(s_issue_rd),
      .busy1(s_busy1), .busy2(s_busy2), .pend_cnt(s_pend_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wd = '0; issue_valid = 1'b0; issue_rd = '0;
   endtask

   initial begin
      rst = 1'b1;
      rd_addr1 = '0; rd_addr2 = '0;
      idle();
      s_rd_addr1 = '0; s_rd_addr2 = '0; s_we = 1'b0; s_waddr = '0; s_wd = '0;
      s_issue_valid = 1'b0; s_issue_rd = '0;
      step(); step();

      rd_addr1 = 5'd3; rd_addr2 = 5'd9; #1;
      check("reset_rd1", rd_data1, 0);
      check("reset_busy1", busy1, 0);
      check("reset_pend", pend_cnt, 0);
      rst = 1'b0;
      step();

      // x0: write and issue are both ignored
      rd_addr1 = 5'd0;
      we = 1'b1; waddr = 5'd0; wd = 32'hFFFF_FFFF;
      issue_valid = 1'b1; issue_rd = 5'd0;
      step(); idle(); #1;
      check("x0_data", rd_data1, 0);
      check("x0_busy", busy1, 0);
      check("x0_pend", pend_cnt, 0);

      // Issue x3, then writeback
      rd_addr1 = 5'd3;
      issue_valid = 1'b1; issue_rd = 5'd3; #1;
      check("x3_busy_pre", busy1, 0);
      step(); idle(); #1;
      check("x3_busy_set", busy1, 1);
      check("x3_pend_set", pend_cnt, 1);
      we = 1'b1; waddr = 5'd3; wd = 32'h1234;
      step(); idle(); #1;
      check("x3_busy_clr", busy1, 0);
      check("x3_data", rd_data1, 32'h1234);
      check("x3_pend_clr", pend_cnt, 0);

      // Same-edge set and clear on x7: set wins, data still written
      issue_valid = 1'b1; issue_rd = 5'd7;
      step(); idle(); #1;
      check("x7_pend1", pend_cnt, 1);
      issue_valid = 1'b1; issue_rd = 5'd7;
      we = 1'b1; waddr = 5'd7; wd = 32'h55;
      step(); idle(); rd_addr1 = 5'd7; #1;
      check("x7_busy", busy1, 1);
      check("x7_pend", pend_cnt, 1);
      check("x7_data", rd_data1, 32'h55);

      // Write to non-busy x9: data lands, busy stays clear
      rd_addr2 = 5'd9;
      we = 1'b1; waddr = 5'd9; wd = 32'h1111_1111;
      step(); idle(); #1;
      check("x9_nb_data", rd_data2, 32'h1111_1111);
      check("x9_nb_busy", busy2, 0);
      check("x9_nb_pend", pend_cnt, 1);

      // Bypass window on port 2
      issue_valid = 1'b1; issue_rd = 5'd9;
      step(); idle(); #1;
      check("x9_busy_set", busy2, 1);
      check("x9_pend2", pend_cnt, 2);
      we = 1'b1; waddr = 5'd9; wd = 32'hA5A5_A5A5; #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_data_pre", rd_data2, 32'hA5A5_A5A5);
      check("byp_busy_pre", busy2, 0);
      issue_valid = 1'b1; issue_rd = 5'd9; #1;
      check("byp_busy_reissue", busy2, 1);
      issue_valid = 1'b0; issue_rd = 5'd0; #1;
`else
      check("byp_data_pre", rd_data2, 32'h1111_1111);
      check("byp_busy_pre", busy2, 1);
`endif
      step(); idle(); #1;
      check("byp_data_post", rd_data2, 32'hA5A5_A5A5);
      check("byp_busy_post", busy2, 0);
      check("byp_pend_post", pend_cnt, 1);

      // Asynchronous reset mid-cycle
      we = 1'b1; waddr = 5'd5; wd = 32'hDEAD_BEEF;
      step(); idle(); rd_addr1 = 5'd5; rd_addr2 = 5'd7; #1;
      check("x5_data", rd_data1, 32'hDEAD_BEEF);
      we = 1'b1; waddr = 5'd6; wd = 32'hCAFE_F00D;
      issue_valid = 1'b1; issue_rd = 5'd4;
      #1 rst = 1'b1; #1;
      check("arst_rd1", rd_data1, 0);
      check("arst_busy2", busy2, 0);
      check("arst_pend", pend_cnt, 0);
      step(); idle(); rst = 1'b0; rd_addr1 = 5'd6; rd_addr2 = 5'd4; #1;
      check("arst_x6_dropped", rd_data1, 0);
      check("arst_x4_dropped", busy2, 0);
      step();
      check("arst_pend_after", pend_cnt, 0);

      // 16 x 64: fill the scoreboard then retire x15
      for (int r = 1; r < 16; r++) begin
         s_issue_valid = 1'b1; s_issue_rd = 4'(r);
         step();
      end
      s_issue_valid = 1'b0; s_issue_rd = '0; #1;
      check("d16_pend_full", s_pend_cnt, 15);
      s_we = 1'b1; s_waddr = 4'd15; s_wd = 64'hFFFF_FFFF_FFFF_FFFF;
      step(); s_we = 1'b0; s_waddr = '0; s_wd = '0;
      s_rd_addr1 = 4'd15; s_rd_addr2 = 4'd14; #1;
      check("d16_pend_14", s_pend_cnt, 14);
      check("d16_data", s_rd_data1, 64'hFFFF_FFFF_FFFF_FFFF);
      check("d16_busy15", s_busy1, 0);
      check("d16_busy14", s_busy2, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
